// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a 5-stage MIPS pipeline.
// Holds the word-indexed PC, a loader-writable instruction memory and the
// IF/ID register. A LOAD/RUN/HALTED controller sequences program load,
// execution and halt. The IF/ID register is flushed to a NOP on redirect,
// on halt and on every re-entry to LOAD.
module fetch_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               start_i,
  input  logic               wr_en_i,
  input  logic [NB_ADDR-1:0] wr_addr_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic               stall_i,
  input  logic               pc_branch_or_jump_i,
  input  logic [1:0]         pc_src_i,
  input  logic [NB_DATA-1:0] address_branch_i,
  input  logic [NB_DATA-1:0] address_jump_i,
  input  logic [NB_DATA-1:0] address_register_i,
  input  logic               halt_i,
  output logic [NB_DATA-1:0] pc_o,
  output logic [NB_DATA-1:0] pc_decode_o,
  output logic [NB_DATA-1:0] instruction_o,
  output logic [1:0]         state_o,
  output logic               halted_o
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam logic [NB_DATA-1:0] NOP     = {NB_DATA{1'b0}};
  localparam logic [NB_DATA-1:0] PC_ZERO = {NB_DATA{1'b0}};
  localparam logic [NB_DATA-1:0] PC_ONE  = NB_DATA'(1);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] pc_decode_q, pc_decode_d;
  logic [NB_DATA-1:0] instruction_q, instruction_d;

  logic [NB_DATA-1:0] mem_q [0:(1<<NB_ADDR)-1];

  logic [NB_DATA-1:0] fetched_s;
  logic [NB_DATA-1:0] pc_plus_one_s;
  logic [NB_DATA-1:0] target_s;
  logic               redirect_s;
  logic               advance_s;

  // Loader writes; only accepted while the controller is in LOAD, contents never reset
  always_ff @(posedge clock_i) begin
    if ((state_q == ST_LOAD) && wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Asynchronous read of the instruction at the current PC (aliases above depth)
  always_comb begin
    fetched_s     = mem_q[pc_q[NB_ADDR-1:0]];
    pc_plus_one_s = pc_q + PC_ONE;
  end

  // Redirect qualification and target selection
  always_comb begin
    redirect_s = pc_branch_or_jump_i & (pc_src_i != 2'b00);
    target_s   = pc_plus_one_s;
    case (pc_src_i)
      2'b01:   target_s = address_branch_i;
      2'b10:   target_s = address_jump_i;
      2'b11:   target_s = address_register_i;
      default: target_s = pc_plus_one_s;
    endcase
  end

  // Pipeline only moves while running, enabled by debug, and not stalled
  always_comb begin
    advance_s = (state_q == ST_RUN) & enable_i & ~stall_i;
  end

  // Next-state, next-PC and IF/ID update (halt > redirect > sequential)
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_decode_d   = pc_decode_q;
    instruction_d = instruction_q;
    case (state_q)
      ST_LOAD: begin
        pc_d          = PC_ZERO;
        pc_decode_d   = PC_ZERO;
        instruction_d = NOP;
        if (start_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (advance_s) begin
          if (halt_i) begin
            pc_decode_d   = PC_ZERO;
            instruction_d = NOP;
            state_d       = ST_HALTED;
          end else if (redirect_s) begin
            pc_d          = target_s;
            pc_decode_d   = PC_ZERO;
            instruction_d = NOP;
          end else begin
            pc_d          = pc_plus_one_s;
            pc_decode_d   = pc_plus_one_s;
            instruction_d = fetched_s;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (start_i) begin
          state_d       = ST_LOAD;
          pc_d          = PC_ZERO;
          pc_decode_d   = PC_ZERO;
          instruction_d = NOP;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d       = ST_LOAD;
        pc_d          = PC_ZERO;
        pc_decode_d   = PC_ZERO;
        instruction_d = NOP;
      end
    endcase
  end

  // State, PC and IF/ID registers with asynchronous active-low reset
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= ST_LOAD;
      pc_q          <= PC_ZERO;
      pc_decode_q   <= PC_ZERO;
      instruction_q <= NOP;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_decode_q   <= pc_decode_d;
      instruction_q <= instruction_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_decode_o   = pc_decode_q;
  assign instruction_o = instruction_q;
  assign state_o       = state_q;
  assign halted_o      = (state_q == ST_HALTED);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, the producer side of the IF/ID interface consumed by the decode stage. Holds the program counter, a loader-writable instruction memory and the IF/ID pipeline register. Applies the decode stage's redirect, stall and halt requests. A three-state controller sequences program load, run and halt under the debug unit.

## Interface
Parameters:
- NB_DATA, 32, data/instruction/PC width
- NB_ADDR, 8, instruction memory index width (2^NB_ADDR words)

Ports:
- clock_i  in  1  single clock, all state updates on rising edge
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  pipeline advance qualifier (debug run/step)
- start_i  in  1  LOAD->RUN, HALTED->LOAD
- wr_en_i  in  1  loader write strobe (honoured only in LOAD)
- wr_addr_i  in  NB_ADDR  loader word address
- wr_data_i  in  NB_DATA  loader instruction word
- stall_i  in  1  hazard stall from decode
- pc_branch_or_jump_i  in  1  decode redirect request
- pc_src_i  in  2  redirect source: 00 sequential, 01 branch, 10 jump, 11 register
- address_branch_i / address_jump_i / address_register_i  in  NB_DATA each  redirect targets
- halt_i  in  1  halt opcode decoded
- pc_o  out  NB_DATA  current fetch PC
- pc_decode_o  out  NB_DATA  IF/ID: fetched PC + 1
- instruction_o  out  NB_DATA  IF/ID: instruction word
- state_o  out  2  00 LOAD, 01 RUN, 10 HALTED
- halted_o  out  1  state_o == HALTED

## Operation
- PC is word-indexed; sequential increment is +1, modulo 2^NB_DATA. Memory index = pc_o[NB_ADDR-1:0] (aliases above depth).
- Memory read is asynchronous (combinational from pc_o); write is synchronous. Memory contents are not reset.
- NOP = 32'h0000_0000; the IF/ID register is loaded with {pc_decode=0, instruction=NOP} whenever flushed.
- redirect = pc_branch_or_jump_i & (pc_src_i != 00). Target: 01 address_branch_i, 10 address_jump_i, 11 address_register_i.
- advance = (state == RUN) & enable_i & !stall_i.
- States:
  - LOAD: PC = 0, IF/ID = NOP. wr_en_i writes mem[wr_addr_i] <= wr_data_i. start_i -> RUN.
  - RUN: on advance, with priority halt > redirect > sequential:
    - halt_i: IF/ID <= NOP, PC holds, -> HALTED.
    - redirect: PC <= target, IF/ID <= NOP (flush, no delay slot).
    - otherwise: IF/ID <= {pc_o+1, mem[pc_o]}, PC <= pc_o+1.
    - When not advancing, PC and IF/ID hold, and redirect and halt are ignored. Decode re-presents them next cycle because its inputs are frozen.
  - HALTED: PC and IF/ID hold. Writes ignored. start_i -> LOAD with PC <= 0, IF/ID <= NOP.
- wr_en_i outside LOAD: no effect. start_i in RUN: no effect.
- Combined cases:
  - stall_i and redirect together: stall wins.
  - halt_i and redirect together: halt wins.
  - start_i and wr_en_i together in LOAD: the write is performed and the state moves to RUN.

## Timing
- Reset (reset_i low, async, any state, mid-operation included):
  - pc_o = 0, pc_decode_o = 0, instruction_o = 0, state_o = 00, halted_o = 0.
  - Memory is untouched.
- Fetch latency: the instruction at pc_o appears on instruction_o one edge after the advance.
- Redirect penalty: one NOP bubble, then the target instruction on the following advance.
- The first RUN edge with advance fetches mem[0].
- Outputs are registered except halted_o, which is decoded directly from the state register.

## Test plan
- Reset mid-run:
  - Stimulus: pc_o = 0x5, reset_i pulsed low between edges.
  - Response: pc_o, pc_decode_o and instruction_o read 0 and state_o reads 00 immediately, before the next edge.
- Load and run:
  - Stimulus: write mem[0..2] = 0x20010005, 0x20020003, 0x00221820; start_i; enable_i = 1.
  - Response: instruction_o = 0x20010005 with pc_decode_o = 1, then 0x20020003 with pc_decode_o = 2, then 0x00221820 with pc_decode_o = 3.
- Branch flush:
  - Stimulus: at pc_o = 3, pc_branch_or_jump_i = 1, pc_src_i = 01, address_branch_i = 0x10.
  - Response: next edge gives instruction_o = 0 and pc_o = 0x10; the following edge gives instruction_o = mem[0x10] and pc_decode_o = 0x11.
- Stall priority:
  - Stimulus: stall_i = 1 for 2 cycles, with redirect (pc_src_i = 10, address_jump_i = 0x40) asserted in both.
  - Response: pc_o, pc_decode_o and instruction_o are unchanged for both cycles.
- enable_i gating:
  - Stimulus: enable_i = 0 for 3 cycles.
  - Response: all outputs hold.
  - Stimulus: one-cycle enable_i pulse.
  - Response: exactly one fetch.
- Halt and reload:
  - Stimulus: halt_i = 1 with a redirect in the same cycle.
  - Response: state_o = 10, halted_o = 1, instruction_o = 0, pc_o unchanged.
  - Stimulus: wr_en_i while HALTED.
  - Response: memory unchanged.
  - Stimulus: start_i.
  - Response: state_o = 00, pc_o = 0.
